// File: rtl/red_pitaya_spi_xfer.sv
// SPI transaction engine for the housekeeping ADC/DAC configuration buses.
// Shifts a header word and a data word out MSB-first. In a read transaction
// the data phase is captured from MISO and returned right-aligned.
//
// Optional feature macro: SPI_XFER_ABORT_EN adds an abort_i input that cuts
// a running transaction short (jump to GAP, done_o still pulses, read-back
// data left untouched).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i, CS high, clk follows registered idle cfg
// LEAD  | CS low for one half period, first MOSI bit already presented
// HDR   | header bits, two half periods each
// DAT   | data bits, MOSI driven on write, MISO sampled on read
// TRAIL | CS low for one half period after the last bit
// GAP   | CS high for one half period, then done_o and back to IDLE

module red_pitaya_spi_xfer (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
`ifdef SPI_XFER_ABORT_EN
    input  logic        abort_i,
`endif
    input  logic [15:0] dat_wr_h_i,
    input  logic [15:0] dat_wr_l_i,
    output logic [15:0] dat_rd_l_o,
    input  logic        cfg_rw_i,
    input  logic [4:0]  cfg_h_lng_i,
    input  logic [4:0]  cfg_l_lng_i,
    input  logic [7:0]  cfg_clk_presc_i,
    input  logic        cfg_clk_idle_i,
    output logic        spi_cs_o,
    output logic        spi_clk_o,
    input  logic        spi_miso_i,
    output logic        spi_mosi_o,
    output logic        spi_mosi_t,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_HDR   = 3'd2;
    localparam logic [2:0] ST_DAT   = 3'd3;
    localparam logic [2:0] ST_TRAIL = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  presc_q;
    logic        half;
    logic [3:0]  bit_idx;
    logic [15:0] h_q;
    logic [15:0] l_q;
    logic [15:0] rd_sh;
    logic [15:0] dat_rd_q;
    logic [4:0]  h_lng_q;
    logic [4:0]  l_lng_q;
    logic        rw_q;
    logic        idle_q;
    logic        idle_cfg_q;
    logic        aborted;
    logic        done_q;

    logic        tick;
    logic        abort_w;
    logic        in_xfer;
    logic [4:0]  h_lng_c;
    logic [4:0]  l_lng_c;
    logic [3:0]  h_top;
    logic [3:0]  l_top;
    logic        mosi_c;
    logic        drive_c;
    logic        clk_c;

`ifdef SPI_XFER_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Lengths above 16 are clamped so the bit index never leaves the word.
    assign h_lng_c = (cfg_h_lng_i > 5'd16) ? 5'd16 : cfg_h_lng_i;
    assign l_lng_c = (cfg_l_lng_i > 5'd16) ? 5'd16 : cfg_l_lng_i;

    // Index of the MSB of each phase; a 4-bit wrap maps length 16 to bit 15.
    assign h_top = h_lng_q[3:0] - 4'd1;
    assign l_top = l_lng_q[3:0] - 4'd1;

    assign tick    = (cnt == presc_q);
    assign in_xfer = (state == ST_LEAD) || (state == ST_HDR) ||
                     (state == ST_DAT)  || (state == ST_TRAIL);

    // Sequencer: prescaler, phase/bit stepping, MISO capture and completion.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            presc_q    <= 8'd0;
            half       <= 1'b0;
            bit_idx    <= 4'd0;
            h_q        <= 16'd0;
            l_q        <= 16'd0;
            rd_sh      <= 16'd0;
            dat_rd_q   <= 16'd0;
            h_lng_q    <= 5'd0;
            l_lng_q    <= 5'd0;
            rw_q       <= 1'b0;
            idle_q     <= 1'b1;
            idle_cfg_q <= 1'b1;
            aborted    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            idle_cfg_q <= cfg_clk_idle_i;
            done_q     <= 1'b0;

            // Counter is parked at 0 in IDLE; GAP's terminal count returns it there.
            if (state != ST_IDLE) begin
                cnt <= tick ? 8'd0 : cnt + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        h_q     <= dat_wr_h_i;
                        l_q     <= dat_wr_l_i;
                        h_lng_q <= h_lng_c;
                        l_lng_q <= l_lng_c;
                        rw_q    <= cfg_rw_i;
                        presc_q <= cfg_clk_presc_i;
                        idle_q  <= cfg_clk_idle_i;
                        rd_sh   <= 16'd0;
                        aborted <= 1'b0;
                        half    <= 1'b0;
                        cnt     <= 8'd0;
                        state   <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        half <= 1'b0;
                        if (h_lng_q != 5'd0) begin
                            state   <= ST_HDR;
                            bit_idx <= h_top;
                        end else if (l_lng_q != 5'd0) begin
                            state   <= ST_DAT;
                            bit_idx <= l_top;
                        end else begin
                            state <= ST_TRAIL;
                        end
                    end
                end
                ST_HDR: begin
                    if (tick) begin
                        half <= ~half;
                        if (half) begin
                            if (bit_idx == 4'd0) begin
                                if (l_lng_q != 5'd0) begin
                                    state   <= ST_DAT;
                                    bit_idx <= l_top;
                                end else begin
                                    state <= ST_TRAIL;
                                end
                            end else begin
                                bit_idx <= bit_idx - 4'd1;
                            end
                        end
                    end
                end
                ST_DAT: begin
                    if (tick) begin
                        half <= ~half;
                        // End of first half: clk returns to idle here, so MISO is taken now.
                        if (!half && rw_q) begin
                            rd_sh <= {rd_sh[14:0], spi_miso_i};
                        end
                        if (half) begin
                            if (bit_idx == 4'd0) begin
                                state <= ST_TRAIL;
                            end else begin
                                bit_idx <= bit_idx - 4'd1;
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                        if (rw_q && !aborted) begin
                            dat_rd_q <= rd_sh;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Abort overrides the normal step; GAP still runs its full half period.
            if (abort_w && in_xfer) begin
                state   <= ST_GAP;
                cnt     <= 8'd0;
                aborted <= 1'b1;
            end
        end
    end

    // Pin decode from the registered state: MOSI value, MOSI enable and SPI clock.
    always_comb begin
        mosi_c  = 1'b0;
        drive_c = 1'b0;
        clk_c   = idle_q;
        case (state)
            ST_IDLE: begin
                clk_c = idle_cfg_q;
            end
            ST_LEAD: begin
                drive_c = 1'b1;
                if (h_lng_q != 5'd0) begin
                    mosi_c = h_q[h_top];
                end else if (!rw_q && (l_lng_q != 5'd0)) begin
                    mosi_c = l_q[l_top];
                end
            end
            ST_HDR: begin
                drive_c = 1'b1;
                mosi_c  = h_q[bit_idx];
                clk_c   = half ? idle_q : ~idle_q;
            end
            ST_DAT: begin
                drive_c = ~rw_q;
                mosi_c  = ~rw_q & l_q[bit_idx];
                clk_c   = half ? idle_q : ~idle_q;
            end
            default: begin
                clk_c = idle_q;
            end
        endcase
    end

    assign spi_cs_o   = ~in_xfer;
    assign spi_clk_o  = clk_c;
    assign spi_mosi_o = mosi_c;
    assign spi_mosi_t = ~drive_c;
    assign busy_o     = (state != ST_IDLE);
    assign done_o     = done_q;
    assign dat_rd_l_o = dat_rd_q;

endmodule

// File: tb/tb_red_pitaya_spi_xfer.sv
// Directed bench for red_pitaya_spi_xfer. Abort scenario only runs when
// SPI_XFER_ABORT_EN is defined for both bench and design.

module tb_red_pitaya_spi_xfer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic        abort_i;
    logic [15:0] dat_wr_h_i;
    logic [15:0] dat_wr_l_i;
    logic [15:0] dat_rd_l_o;
    logic        cfg_rw_i;
    logic [4:0]  cfg_h_lng_i;
    logic [4:0]  cfg_l_lng_i;
    logic [7:0]  cfg_clk_presc_i;
    logic        cfg_clk_idle_i;
    logic        spi_cs_o;
    logic        spi_clk_o;
    logic        spi_miso_i;
    logic        spi_mosi_o;
    logic        spi_mosi_t;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // capture results of run_xfer
    int          busy_cnt, cs_low_cnt, drive_cnt, clk_tog, rise_cnt, cs_high_after, done_early, z_nonzero;
    logic [31:0] mosi_bits;
    logic        c1_busy, c1_cs, c1_mosi, c1_mosi_t, end_done, timeout;
    logic [15:0] end_rd;

    // MISO slave model (mode 3: change on falling clk)
    int          fall_cnt = 0;
    int          miso_h = 0;
    int          miso_l = 0;
    logic [15:0] miso_word = 16'h0000;

    always #5 clk_i = ~clk_i;

    red_pitaya_spi_xfer dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
`ifdef SPI_XFER_ABORT_EN
        .abort_i        (abort_i),
`endif
        .dat_wr_h_i     (dat_wr_h_i),
        .dat_wr_l_i     (dat_wr_l_i),
        .dat_rd_l_o     (dat_rd_l_o),
        .cfg_rw_i       (cfg_rw_i),
        .cfg_h_lng_i    (cfg_h_lng_i),
        .cfg_l_lng_i    (cfg_l_lng_i),
        .cfg_clk_presc_i(cfg_clk_presc_i),
        .cfg_clk_idle_i (cfg_clk_idle_i),
        .spi_cs_o       (spi_cs_o),
        .spi_clk_o      (spi_clk_o),
        .spi_miso_i     (spi_miso_i),
        .spi_mosi_o     (spi_mosi_o),
        .spi_mosi_t     (spi_mosi_t),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always @(negedge spi_clk_o or posedge spi_cs_o) begin
        if (spi_cs_o) begin
            fall_cnt   = 0;
            spi_miso_i = 1'b0;
        end else begin
            if (fall_cnt >= miso_h && fall_cnt < miso_h + miso_l)
                spi_miso_i = miso_word[miso_l - 1 - (fall_cnt - miso_h)];
            else
                spi_miso_i = 1'b0;
            fall_cnt++;
        end
    end

    task automatic set_cfg(input logic rw, input int hl, input int ll, input int presc,
                           input logic [15:0] h, input logic [15:0] l);
        cfg_rw_i        = rw;
        cfg_h_lng_i     = 5'(hl);
        cfg_l_lng_i     = 5'(ll);
        cfg_clk_presc_i = 8'(presc);
        dat_wr_h_i      = h;
        dat_wr_l_i      = l;
    endtask

    // Pulses start (unless already raised), then samples every cycle until busy drops.
    // mid_cyc > 0 re-pulses start with junk data; restart raises start in the done cycle.
    task automatic run_xfer(input logic skip_start, input int mid_cyc, input logic restart,
                            input logic [15:0] nh, input logic [15:0] nl);
        int   cyc;
        logic prev_clk;
        logic seen_low;
        busy_cnt = 0; cs_low_cnt = 0; drive_cnt = 0; clk_tog = 0; rise_cnt = 0;
        cs_high_after = 0; done_early = 0; z_nonzero = 0; mosi_bits = 32'd0;
        end_done = 1'b0; end_rd = 16'd0; timeout = 1'b1; seen_low = 1'b0;
        if (!skip_start) begin
            @(negedge clk_i);
            start_i = 1'b1;
        end
        prev_clk = spi_clk_o;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1;
        c1_busy = busy_o; c1_cs = spi_cs_o; c1_mosi = spi_mosi_o; c1_mosi_t = spi_mosi_t;
        while (cyc < 4000) begin
            if (!spi_cs_o) begin
                cs_low_cnt++;
                seen_low = 1'b1;
                if (!spi_mosi_t) drive_cnt++;
            end else if (seen_low) begin
                cs_high_after++;
            end
            if (spi_mosi_t && spi_mosi_o) z_nonzero++;
            if (spi_clk_o != prev_clk) clk_tog++;
            if (!prev_clk && spi_clk_o) begin
                mosi_bits = {mosi_bits[30:0], spi_mosi_o};
                rise_cnt++;
            end
            prev_clk = spi_clk_o;
            if (!busy_o) begin
                end_done = done_o;
                end_rd   = dat_rd_l_o;
                timeout  = 1'b0;
                if (restart) begin
                    start_i = 1'b1;
                    set_cfg(1'b0, 8, 8, 1, nh, nl);
                end
                break;
            end
            busy_cnt++;
            if (done_o) done_early++;
            if (cyc == mid_cyc) begin
                start_i = 1'b1;
                set_cfg(1'b1, 16, 16, 0, 16'hFFFF, 16'hFFFF);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; cfg_clk_idle_i = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 16'h0, 16'h0);
        repeat (2) @(negedge clk_i);
        n_checks++; if (spi_cs_o !== 1'b1) begin $display("FAIL reset_cs: got %b expected 1", spi_cs_o); n_fail++; end
        n_checks++; if (spi_clk_o !== 1'b1) begin $display("FAIL reset_clk: got %b expected 1", spi_clk_o); n_fail++; end
        n_checks++; if (spi_mosi_o !== 1'b0) begin $display("FAIL reset_mosi: got %b expected 0", spi_mosi_o); n_fail++; end
        n_checks++; if (spi_mosi_t !== 1'b1) begin $display("FAIL reset_mosi_t: got %b expected 1", spi_mosi_t); n_fail++; end
        n_checks++; if (busy_o !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy_o); n_fail++; end
        n_checks++; if (done_o !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done_o); n_fail++; end
        n_checks++; if (dat_rd_l_o !== 16'h0) begin $display("FAIL reset_rd: got %h expected 0000", dat_rd_l_o); n_fail++; end
        rstn_i = 1'b1;
        @(negedge clk_i);
        n_checks++; if (spi_clk_o !== 1'b0) begin $display("FAIL idle_clk_follow: got %b expected 0", spi_clk_o); n_fail++; end
        cfg_clk_idle_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_write;
        set_cfg(1'b0, 8, 8, 1, 16'h000A, 16'h00C3);
        run_xfer(1'b0, 0, 1'b0, 16'h0, 16'h0);
        n_checks++; if (c1_busy !== 1'b1 || c1_cs !== 1'b0 || c1_mosi_t !== 1'b0) begin $display("FAIL wr_cycle1: got busy=%b cs=%b mosi_t=%b expected 1 0 0", c1_busy, c1_cs, c1_mosi_t); n_fail++; end
        n_checks++; if (busy_cnt !== 70 || timeout) begin $display("FAIL wr_busy_len: got %0d expected 70", busy_cnt); n_fail++; end
        n_checks++; if (rise_cnt !== 16 || mosi_bits[15:0] !== 16'h0AC3) begin $display("FAIL wr_mosi_bits: got %0d bits %h expected 16 bits 0ac3", rise_cnt, mosi_bits[15:0]); n_fail++; end
        n_checks++; if (drive_cnt !== 66) begin $display("FAIL wr_mosi_t_drive: got %0d expected 66", drive_cnt); n_fail++; end
        n_checks++; if (cs_low_cnt !== 68) begin $display("FAIL wr_cs_low: got %0d expected 68", cs_low_cnt); n_fail++; end
        n_checks++; if (end_done !== 1'b1 || done_early !== 0) begin $display("FAIL wr_done: got end=%b early=%0d expected 1 0", end_done, done_early); n_fail++; end
        n_checks++; if (end_rd !== 16'h0000) begin $display("FAIL wr_rd_unchanged: got %h expected 0000", end_rd); n_fail++; end
        n_checks++; if (z_nonzero !== 0) begin $display("FAIL wr_mosi_zero: got %0d expected 0", z_nonzero); n_fail++; end
    endtask

    task automatic test_read;
        miso_h = 16; miso_l = 8; miso_word = 16'h00A5;
        set_cfg(1'b1, 16, 8, 0, 16'h8012, 16'hFFFF);
        run_xfer(1'b0, 0, 1'b0, 16'h0, 16'h0);
        n_checks++; if (c1_mosi !== 1'b1) begin $display("FAIL rd_first_bit: got %b expected 1", c1_mosi); n_fail++; end
        n_checks++; if (busy_cnt !== 51 || timeout) begin $display("FAIL rd_busy_len: got %0d expected 51", busy_cnt); n_fail++; end
        n_checks++; if (rise_cnt !== 24 || mosi_bits[23:0] !== 24'h801200) begin $display("FAIL rd_mosi_bits: got %0d bits %h expected 24 bits 801200", rise_cnt, mosi_bits[23:0]); n_fail++; end
        n_checks++; if (drive_cnt !== 33) begin $display("FAIL rd_mosi_t_data: got %0d expected 33", drive_cnt); n_fail++; end
        n_checks++; if (end_done !== 1'b1) begin $display("FAIL rd_done: got %b expected 1", end_done); n_fail++; end
        n_checks++; if (end_rd !== 16'h00A5) begin $display("FAIL rd_data: got %h expected 00a5", end_rd); n_fail++; end
        n_checks++; if (cs_high_after !== 2) begin $display("FAIL rd_gap_len: got %0d expected 2", cs_high_after); n_fail++; end
    endtask

    task automatic test_zero_len;
        set_cfg(1'b0, 0, 0, 3, 16'hFFFF, 16'hFFFF);
        run_xfer(1'b0, 0, 1'b0, 16'h0, 16'h0);
        n_checks++; if (busy_cnt !== 12 || timeout) begin $display("FAIL zl_busy_len: got %0d expected 12", busy_cnt); n_fail++; end
        n_checks++; if (cs_low_cnt !== 8) begin $display("FAIL zl_cs_low: got %0d expected 8", cs_low_cnt); n_fail++; end
        n_checks++; if (clk_tog !== 0) begin $display("FAIL zl_clk_toggles: got %0d expected 0", clk_tog); n_fail++; end
        n_checks++; if (end_done !== 1'b1) begin $display("FAIL zl_done: got %b expected 1", end_done); n_fail++; end
        n_checks++; if (c1_mosi !== 1'b0 || end_rd !== 16'h00A5) begin $display("FAIL zl_mosi_rd: got mosi=%b rd=%h expected 0 00a5", c1_mosi, end_rd); n_fail++; end
    endtask

    task automatic test_back_to_back;
        set_cfg(1'b0, 8, 8, 1, 16'h000A, 16'h00C3);
        run_xfer(1'b0, 20, 1'b1, 16'h005A, 16'h003C);
        n_checks++; if (mosi_bits[15:0] !== 16'h0AC3 || busy_cnt !== 70) begin $display("FAIL b2b_first: got bits %h busy %0d expected 0ac3 70", mosi_bits[15:0], busy_cnt); n_fail++; end
        n_checks++; if (cs_high_after !== 3) begin $display("FAIL b2b_cs_high: got %0d expected 3", cs_high_after); n_fail++; end
        run_xfer(1'b1, 0, 1'b0, 16'h0, 16'h0);
        n_checks++; if (c1_busy !== 1'b1 || c1_cs !== 1'b0) begin $display("FAIL b2b_launch: got busy=%b cs=%b expected 1 0", c1_busy, c1_cs); n_fail++; end
        n_checks++; if (mosi_bits[15:0] !== 16'h5A3C || busy_cnt !== 70) begin $display("FAIL b2b_second: got bits %h busy %0d expected 5a3c 70", mosi_bits[15:0], busy_cnt); n_fail++; end
    endtask

    task automatic test_reset_mid;
        int dn;
        cfg_clk_idle_i = 1'b0;
        set_cfg(1'b1, 16, 8, 0, 16'h8012, 16'h0000);
        n_checks++; if (dat_rd_l_o !== 16'h00A5) begin $display("FAIL rm_prior_rd: got %h expected 00a5", dat_rd_l_o); n_fail++; end
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (7) @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b1 || spi_cs_o !== 1'b0) begin $display("FAIL rm_in_hdr: got busy=%b cs=%b expected 1 0", busy_o, spi_cs_o); n_fail++; end
        rstn_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (spi_cs_o !== 1'b1 || spi_clk_o !== 1'b1) begin $display("FAIL rm_pins: got cs=%b clk=%b expected 1 1", spi_cs_o, spi_clk_o); n_fail++; end
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || spi_mosi_t !== 1'b1) begin $display("FAIL rm_status: got busy=%b done=%b mosi_t=%b expected 0 0 1", busy_o, done_o, spi_mosi_t); n_fail++; end
        n_checks++; if (dat_rd_l_o !== 16'h0000) begin $display("FAIL rm_rd_clear: got %h expected 0000", dat_rd_l_o); n_fail++; end
        rstn_i = 1'b1;
        cfg_clk_idle_i = 1'b1;
        dn = 0;
        repeat (5) begin @(negedge clk_i); if (done_o) dn++; end
        n_checks++; if (dn !== 0) begin $display("FAIL rm_no_done: got %0d expected 0", dn); n_fail++; end
    endtask

`ifdef SPI_XFER_ABORT_EN
    task automatic test_abort;
        int k;
        miso_h = 16; miso_l = 8; miso_word = 16'h00A5;
        set_cfg(1'b1, 16, 8, 0, 16'h8012, 16'h0000);
        run_xfer(1'b0, 0, 1'b0, 16'h0, 16'h0);
        n_checks++; if (end_rd !== 16'h00A5) begin $display("FAIL ab_setup_rd: got %h expected 00a5", end_rd); n_fail++; end
        miso_word = 16'h003C;
        set_cfg(1'b1, 16, 8, 1, 16'h8012, 16'h0000);
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (69) @(negedge clk_i);
        n_checks++; if (spi_cs_o !== 1'b0 || spi_mosi_t !== 1'b1) begin $display("FAIL ab_in_dat: got cs=%b mosi_t=%b expected 0 1", spi_cs_o, spi_mosi_t); n_fail++; end
        abort_i = 1'b1;
        @(negedge clk_i); abort_i = 1'b0;
        n_checks++; if (spi_cs_o !== 1'b1 || spi_clk_o !== 1'b1 || spi_mosi_t !== 1'b1 || busy_o !== 1'b1) begin $display("FAIL ab_gap: got cs=%b clk=%b mosi_t=%b busy=%b expected 1 1 1 1", spi_cs_o, spi_clk_o, spi_mosi_t, busy_o); n_fail++; end
        k = 0;
        while (busy_o && k < 50) begin @(negedge clk_i); k++; end
        n_checks++; if (k !== 2 || done_o !== 1'b1) begin $display("FAIL ab_done_delay: got %0d done=%b expected 2 1", k, done_o); n_fail++; end
        n_checks++; if (dat_rd_l_o !== 16'h00A5) begin $display("FAIL ab_rd_kept: got %h expected 00a5", dat_rd_l_o); n_fail++; end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_XFER_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
